// File: rtl/rv32i_types.sv
// ============================================================================
// Module : rv32i_types (package)
// Brief  : Shared types for the memory-side arbitration path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } pmem_arb_state_t;

endpackage : rv32i_types

`default_nettype wire

// File: rtl/pmem_arbiter.sv
// ============================================================================
// Module : pmem_arbiter
// Brief  : Shares one cacheline adaptor between I-cache and D-cache.
//          Define PMEM_ARB_RR_EN for round-robin conflicts (default: D wins).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pmem_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [31:0]       i_pmem_address,
    input  logic              i_pmem_read,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic [31:0]       d_pmem_address,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic [31:0]       pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    pmem_arb_state_t state_q;
    pmem_arb_state_t state_d;

    logic w_i_req;
    logic w_d_req;
    logic w_d_wins;

    assign w_i_req = i_pmem_read;
    assign w_d_req = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_RR_EN
    // Set when the D-cache received the most recent grant.
    logic last_d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else if ((state_q == IDLE) && (state_d != IDLE)) begin
            last_d_q <= (state_d == SERVE_D);
        end
    end

    assign w_d_wins = ~last_d_q;
`else
    assign w_d_wins = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (w_i_req && w_d_req) begin
                    state_d = w_d_wins ? SERVE_D : SERVE_I;
                end else if (w_d_req) begin
                    state_d = SERVE_D;
                end else if (w_i_req) begin
                    state_d = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields follow the granted requester combinationally, so a
    // requester that drops early simply stops driving the adaptor.
    always_comb begin
        pmem_address = 32'h0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        case (state_q)
            SERVE_I: begin
                pmem_address = i_pmem_address;
                pmem_read    = i_pmem_read;
                i_pmem_resp  = pmem_resp;
            end
            SERVE_D: begin
                pmem_address = d_pmem_address;
                pmem_read    = d_pmem_read;
                pmem_write   = d_pmem_write;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
            end
            default: ;
        endcase
    end

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule : pmem_arbiter

`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
// ============================================================================
// Module : tb_pmem_arbiter
// Brief  : Directed self-checking bench for pmem_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pmem_arbiter;

    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   i_pmem_address = '0;
    logic          i_pmem_read = 1'b0;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic [31:0]   d_pmem_address = '0;
    logic          d_pmem_read = 1'b0;
    logic          d_pmem_write = 1'b0;
    logic [LW-1:0] d_pmem_wdata = '0;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic [31:0]   pmem_address;
    logic          pmem_read;
    logic          pmem_write;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [LW-1:0] pat_a;
    logic [LW-1:0] pat_b;

    pmem_arbiter #(.LINE_W(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_address (i_pmem_address),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_address (d_pmem_address),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_address   (pmem_address),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'hDEAD_BEEF;
        pmem_resp      = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || pmem_address !== 32'h0 || pmem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_outputs: rd=%b wr=%b addr=%h (want 0 0 0)", pmem_read, pmem_write, pmem_address);
        end
        checks++;
        if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
            failures++;
            $display("FAIL reset_resp: i=%b d=%b (want 0 0)", i_pmem_resp, d_pmem_resp);
        end
        @(negedge clk);
        i_pmem_read = 1'b0;
        pmem_resp   = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic test_i_read();
        int hi_cnt = 0;
        @(negedge clk);
        i_pmem_address = 32'h0000_1000;
        i_pmem_read    = 1'b1;
        #1;
        checks++;
        if (pmem_read !== 1'b0) begin
            failures++;
            $display("FAIL i_grant_latency: pmem_read=%b want 0", pmem_read);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 4) begin
                pmem_rdata = pat_a;
                pmem_resp  = 1'b1;
            end
            #1;
            if (pmem_read === 1'b1) hi_cnt++;
            if (k == 1) begin
                checks++;
                if (pmem_address !== 32'h0000_1000 || pmem_write !== 1'b0 || pmem_wdata !== '0) begin
                    failures++;
                    $display("FAIL i_read_fields: addr=%h wr=%b want 00001000 0", pmem_address, pmem_write);
                end
            end
            if (k == 2) begin
                checks++;
                if (i_pmem_resp !== 1'b0) begin
                    failures++;
                    $display("FAIL i_early_resp: i_pmem_resp=%b want 0", i_pmem_resp);
                end
            end
        end
        checks++;
        if (i_pmem_resp !== 1'b1 || i_pmem_rdata !== pat_a || d_pmem_resp !== 1'b0) begin
            failures++;
            $display("FAIL i_read_resp: i_resp=%b d_resp=%b rdata_ok=%b want 1 0 1",
                     i_pmem_resp, d_pmem_resp, i_pmem_rdata === pat_a);
        end
        checks++;
        if (d_pmem_rdata !== pat_a) begin
            failures++;
            $display("FAIL rdata_broadcast: d_pmem_rdata differs from adaptor rdata");
        end
        @(negedge clk);
        pmem_resp   = 1'b0;
        i_pmem_read = 1'b0;
        #1;
        checks++;
        if (pmem_read !== 1'b0 || i_pmem_resp !== 1'b0) begin
            failures++;
            $display("FAIL i_read_done: pmem_read=%b i_resp=%b want 0 0", pmem_read, i_pmem_resp);
        end
        checks++;
        if (hi_cnt != 4) begin
            failures++;
            $display("FAIL i_read_cycles: pmem_read high %0d cycles want 4", hi_cnt);
        end
    endtask

    task automatic test_d_write();
        int resp_cnt = 0;
        @(negedge clk);
        d_pmem_address = 32'h0000_2020;
        d_pmem_wdata   = pat_b;
        d_pmem_write   = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 2) pmem_resp = 1'b1;
            if (k == 3) begin
                pmem_resp    = 1'b0;
                d_pmem_write = 1'b0;
            end
            #1;
            if (d_pmem_resp === 1'b1) resp_cnt++;
            if (k == 1) begin
                checks++;
                if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'h0000_2020 || pmem_wdata !== pat_b) begin
                    failures++;
                    $display("FAIL d_write_fields: wr=%b rd=%b addr=%h wdata_ok=%b want 1 0 00002020 1",
                             pmem_write, pmem_read, pmem_address, pmem_wdata === pat_b);
                end
            end
            if (k == 2) begin
                checks++;
                if (i_pmem_resp !== 1'b0) begin
                    failures++;
                    $display("FAIL d_write_iresp: i_pmem_resp=%b want 0", i_pmem_resp);
                end
            end
        end
        checks++;
        if (resp_cnt != 1) begin
            failures++;
            $display("FAIL d_write_resp_count: %0d pulses want 1", resp_cnt);
        end
    endtask

    task automatic test_conflict();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        i_pmem_address = 32'h0000_3000;
        i_pmem_read    = 1'b1;
        d_pmem_address = 32'h0000_4040;
        d_pmem_read    = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (pmem_address !== 32'h0000_4040 || pmem_read !== 1'b1) begin
            failures++;
            $display("FAIL conflict_first_d: addr=%h rd=%b want 00004040 1", pmem_address, pmem_read);
        end
        pmem_resp = 1'b1;
        #1;
        checks++;
        if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0) begin
            failures++;
            $display("FAIL conflict_d_resp: d=%b i=%b want 1 0", d_pmem_resp, i_pmem_resp);
        end
        @(negedge clk);
        pmem_resp   = 1'b0;
        d_pmem_read = 1'b0;
        #1;
        checks++;
        if (pmem_read !== 1'b0 || pmem_address !== 32'h0) begin
            failures++;
            $display("FAIL conflict_turnaround: rd=%b addr=%h want 0 00000000", pmem_read, pmem_address);
        end
        @(negedge clk); #1;
        checks++;
        if (pmem_address !== 32'h0000_3000 || pmem_read !== 1'b1) begin
            failures++;
            $display("FAIL conflict_then_i: addr=%h rd=%b want 00003000 1", pmem_address, pmem_read);
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp   = 1'b0;
        i_pmem_read = 1'b0;
    endtask

    // Last grant is made to D, then a conflict: round-robin picks I.
    task automatic test_second_conflict();
        logic [31:0] exp_addr;
`ifdef PMEM_ARB_RR_EN
        exp_addr = 32'h0000_5000;
`else
        exp_addr = 32'h0000_6060;
`endif
        @(negedge clk);
        d_pmem_address = 32'h0000_7000;
        d_pmem_read    = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp      = 1'b0;
        i_pmem_address = 32'h0000_5000;
        i_pmem_read    = 1'b1;
        d_pmem_address = 32'h0000_6060;
        d_pmem_read    = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (pmem_address !== exp_addr) begin
            failures++;
            $display("FAIL second_conflict: addr=%h want %h", pmem_address, exp_addr);
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        @(negedge clk);
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp   = 1'b0;
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        #1;
        checks++;
        if (pmem_read !== 1'b0) begin
            failures++;
            $display("FAIL second_conflict_drain: rd=%b want 0", pmem_read);
        end
    endtask

    task automatic test_d_during_i();
        @(negedge clk);
        i_pmem_address = 32'h0000_8000;
        i_pmem_read    = 1'b1;
        @(negedge clk);
        d_pmem_address = 32'h0000_9000;
        d_pmem_read    = 1'b1;
        #1;
        checks++;
        if (pmem_address !== 32'h0000_8000 || d_pmem_resp !== 1'b0) begin
            failures++;
            $display("FAIL d_wait_addr: addr=%h d_resp=%b want 00008000 0", pmem_address, d_pmem_resp);
        end
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        checks++;
        if (pmem_address !== 32'h0000_8000 || i_pmem_resp !== 1'b1 || d_pmem_resp !== 1'b0) begin
            failures++;
            $display("FAIL d_wait_i_done: addr=%h i=%b d=%b want 00008000 1 0",
                     pmem_address, i_pmem_resp, d_pmem_resp);
        end
        @(negedge clk);
        pmem_resp   = 1'b0;
        i_pmem_read = 1'b0;
        #1;
        checks++;
        if (pmem_read !== 1'b0) begin
            failures++;
            $display("FAIL d_wait_idle: rd=%b want 0", pmem_read);
        end
        @(negedge clk); #1;
        checks++;
        if (pmem_address !== 32'h0000_9000 || pmem_read !== 1'b1) begin
            failures++;
            $display("FAIL d_wait_serve: addr=%h rd=%b want 00009000 1", pmem_address, pmem_read);
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp   = 1'b0;
        d_pmem_read = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        d_pmem_address = 32'h0000_A000;
        d_pmem_read    = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (pmem_read !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre: rd=%b want 1", pmem_read);
        end
        rst       = 1'b1;
        pmem_resp = 1'b1;
        #1;
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || d_pmem_resp !== 1'b0 || pmem_address !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_drop: rd=%b wr=%b d_resp=%b addr=%h want 0 0 0 00000000",
                     pmem_read, pmem_write, d_pmem_resp, pmem_address);
        end
        @(negedge clk);
        rst         = 1'b0;
        pmem_resp   = 1'b0;
        d_pmem_read = 1'b0;
        @(negedge clk);
        i_pmem_address = 32'h0000_B000;
        i_pmem_read    = 1'b1;
        @(negedge clk);
        pmem_rdata = pat_b;
        pmem_resp  = 1'b1;
        #1;
        checks++;
        if (pmem_address !== 32'h0000_B000 || i_pmem_resp !== 1'b1 || i_pmem_rdata !== pat_b) begin
            failures++;
            $display("FAIL rst_mid_recover: addr=%h i_resp=%b want 0000B000 1", pmem_address, i_pmem_resp);
        end
        @(negedge clk);
        pmem_resp   = 1'b0;
        i_pmem_read = 1'b0;
    endtask

    initial begin
        pat_a = {8{32'hA5A5_0001}};
        pat_b = {8{32'h5A5A_F00D}};
        test_reset();
        test_i_read();
        test_d_write();
        test_conflict();
        test_second_conflict();
        test_d_during_i();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pmem_arbiter

`default_nettype wire
